// File: rtl/lf_pkg.sv
// Shared encodings for the line-follower motor controller.
// Commands, per-motor drive codes and motion targets.
package lf_pkg;

  localparam logic [2:0] CMD_AUTO    = 3'b000;
  localparam logic [2:0] CMD_FORWARD = 3'b001;
  localparam logic [2:0] CMD_RIGHT   = 3'b010;
  localparam logic [2:0] CMD_LEFT    = 3'b011;
  localparam logic [2:0] CMD_STOP    = 3'b100;
  localparam logic [2:0] CMD_REVERSE = 3'b101;

  localparam logic [1:0] DRV_OFF = 2'b00;
  localparam logic [1:0] DRV_REV = 2'b01;
  localparam logic [1:0] DRV_FWD = 2'b10;

  typedef struct packed {
    logic [1:0] m1;
    logic [1:0] m2;
  } tgt_t;

  localparam tgt_t TGT_FORWARD = '{m1: DRV_FWD, m2: DRV_FWD};
  localparam tgt_t TGT_RIGHT   = '{m1: DRV_FWD, m2: DRV_OFF};
  localparam tgt_t TGT_LEFT    = '{m1: DRV_OFF, m2: DRV_FWD};
  localparam tgt_t TGT_STOP    = '{m1: DRV_OFF, m2: DRV_OFF};
  localparam tgt_t TGT_REVERSE = '{m1: DRV_REV, m2: DRV_REV};

endpackage

// File: rtl/motor_deadtime.sv
// One motor's registered H-bridge drive with reversal dead-time.
// Ports: clk, rst_n, tgt (target drive), a (fwd), b (rev).
module motor_deadtime
  import lf_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tgt,
  output logic       a,
  output logic       b
);

  localparam logic [3:0] CNT_INIT = 4'(DEAD_CYCLES);

  logic [1:0] drv, drv_n;
  logic [3:0] cnt, cnt_n;
  logic       rev;

  assign rev = (drv == DRV_FWD && tgt == DRV_REV) ||
               (drv == DRV_REV && tgt == DRV_FWD);

  always_comb begin
    drv_n = drv;
    cnt_n = cnt;
    if (cnt != 4'd0) begin
      // dead-time running: output is OFF
      if (tgt == DRV_OFF) begin
        drv_n = DRV_OFF;
        cnt_n = 4'd0;
      end else if (cnt == 4'd1) begin
        drv_n = tgt;
        cnt_n = 4'd0;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end else if (rev) begin
      drv_n = DRV_OFF;
      cnt_n = CNT_INIT;
    end else begin
      drv_n = tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv <= DRV_OFF;
      cnt <= 4'd0;
    end else begin
      drv <= drv_n;
      cnt <= cnt_n;
    end
  end

  assign a = drv[1];
  assign b = drv[0];

endmodule

// File: rtl/line_follower_voice.sv
// Line-follower motor controller with voice-command override.
// Ports: clk, rst_n, s1/s2 sensors, cmd voice command, m1a/m1b/m2a/m2b.
module line_follower_voice
  import lf_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s1,
  input  logic       s2,
  input  logic [2:0] cmd,
  output logic       m1a,
  output logic       m1b,
  output logic       m2a,
  output logic       m2b
);

  logic [2:0] cmd_q;
  logic [1:0] s_meta;
  logic [1:0] s_sync;
  tgt_t       tgt;
  tgt_t       auto_tgt;

  // sensors reset to "line lost" so the robot holds still
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= CMD_STOP;
      s_meta <= 2'b11;
      s_sync <= 2'b11;
    end else begin
      cmd_q  <= cmd;
      s_meta <= {s1, s2};
      s_sync <= s_meta;
    end
  end

  always_comb begin
    auto_tgt = TGT_STOP;
    unique case (s_sync)
      2'b00:   auto_tgt = TGT_FORWARD;
      2'b10:   auto_tgt = TGT_RIGHT;
      2'b01:   auto_tgt = TGT_LEFT;
      default: auto_tgt = TGT_STOP;
    endcase
  end

  always_comb begin
    tgt = TGT_STOP;
    unique case (cmd_q)
      CMD_AUTO:    tgt = auto_tgt;
      CMD_FORWARD: tgt = TGT_FORWARD;
      CMD_RIGHT:   tgt = TGT_RIGHT;
      CMD_LEFT:    tgt = TGT_LEFT;
      CMD_REVERSE: tgt = TGT_REVERSE;
      default:     tgt = TGT_STOP;
    endcase
  end

  motor_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_m1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tgt   (tgt.m1),
    .a     (m1a),
    .b     (m1b)
  );

  motor_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_m2 (
    .clk   (clk),
    .rst_n (rst_n),
    .tgt   (tgt.m2),
    .a     (m2a),
    .b     (m2b)
  );

endmodule

// File: tb/tb_line_follower_voice.sv
// Bench for line_follower_voice: directed literals plus random stimulus
// checked every cycle against a behavioural model.
module tb_line_follower_voice;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s1 = 1'b1;
  logic       s2 = 1'b1;
  logic [2:0] cmd = 3'b100;
  logic       m1a, m1b, m2a, m2b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_follower_voice #(.DEAD_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s1    (s1),
    .s2    (s2),
    .cmd   (cmd),
    .m1a   (m1a),
    .m1b   (m1b),
    .m2a   (m2a),
    .m2b   (m2b)
  );

  // model: drives as 0=OFF 1=FWD 2=REV
  bit [2:0] cq[$] = '{3'b100};
  bit [1:0] sq[$] = '{2'b11, 2'b11};
  int mo[2] = '{0, 0};
  bit hold[2] = '{0, 0};
  int hold_end[2] = '{0, 0};
  int cyc = 0;

  function automatic int motion(bit [2:0] c, bit [1:0] s, int m);
    int p1, p2;
    p1 = 0; p2 = 0;
    case (c)
      3'd0: begin
        if (s == 2'b00) begin p1 = 1; p2 = 1; end
        else if (s == 2'b10) p1 = 1;
        else if (s == 2'b01) p2 = 1;
      end
      3'd1: begin p1 = 1; p2 = 1; end
      3'd2: p1 = 1;
      3'd3: p2 = 1;
      3'd5: begin p1 = 2; p2 = 2; end
      default: ;
    endcase
    return (m == 0) ? p1 : p2;
  endfunction

  function automatic logic [1:0] bits(int d);
    return (d == 1) ? 2'b10 : (d == 2) ? 2'b01 : 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [2:0] c;
    bit [1:0] s;
    int t;
    if (!rst_n) begin
      cq = '{3'b100};
      sq = '{2'b11, 2'b11};
      mo = '{0, 0};
      hold = '{0, 0};
      cyc = 0;
    end else begin
      // target this edge: cmd seen one edge ago, sensors two edges ago
      c = cq.pop_front();
      s = sq.pop_front();
      cq.push_back(cmd);
      sq.push_back({s1, s2});
      cyc++;
      for (int m = 0; m < 2; m++) begin
        t = motion(c, s, m);
        if (hold[m]) begin
          if (t == 0) begin
            hold[m] = 0;
            mo[m] = 0;
          end else if (cyc == hold_end[m]) begin
            hold[m] = 0;
            mo[m] = t;
          end else begin
            mo[m] = 0;
          end
        end else if ((mo[m] == 1 && t == 2) || (mo[m] == 2 && t == 1)) begin
          mo[m] = 0;
          hold[m] = 1;
          hold_end[m] = cyc + D;
        end else begin
          mo[m] = t;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] got, exp;
    got = {m1a, m1b, m2a, m2b};
    exp = {bits(mo[0]), bits(mo[1])};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model t=%0t got=%b expected=%b", $time, got, exp);
    end
    checks++;
    if ((m1a & m1b) | (m2a & m2b)) begin
      failures++;
      $display("FAIL illegal11 t=%0t got=%b expected no 11 pair", $time, got);
    end
  end

  task automatic lit(input string name, input logic [3:0] v);
    logic [3:0] got;
    got = {m1a, m1b, m2a, m2b};
    checks++;
    if (got !== v) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, v);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fresh_reset();
    rst_n = 1'b0;
    cmd = 3'b000;
    s1 = 1'b0;
    s2 = 1'b0;
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(1); lit("rst_c1", 4'b0000);
    cyc_n(1); lit("rst_c2", 4'b0000);
    cyc_n(1); lit("rst_c3", 4'b1010);
  endtask

  initial begin
    fresh_reset();
    cyc_n(5);
    // auto mode sensor patterns
    {s1, s2} = 2'b10;
    cyc_n(2); lit("s10_early", 4'b1010);
    cyc_n(1); lit("s10", 4'b1000);
    cyc_n(7);
    {s1, s2} = 2'b01;
    cyc_n(2); lit("s01_early", 4'b1000);
    cyc_n(1); lit("s01", 4'b0010);
    cyc_n(7);
    {s1, s2} = 2'b11;
    cyc_n(3); lit("s11", 4'b0000);
    cyc_n(7);
    // manual commands
    cmd = 3'b001;
    cyc_n(1); lit("fwd_early", 4'b0000);
    cyc_n(1); lit("fwd", 4'b1010);
    cyc_n(8);
    cmd = 3'b010; cyc_n(2); lit("right", 4'b1000); cyc_n(8);
    cmd = 3'b011; cyc_n(2); lit("left", 4'b0010); cyc_n(8);
    cmd = 3'b100; cyc_n(2); lit("stop", 4'b0000); cyc_n(8);
    // reversal with dead-time
    cmd = 3'b001; cyc_n(10); lit("rev_pre", 4'b1010);
    cmd = 3'b101;
    cyc_n(1); lit("rev_c1", 4'b1010);
    cyc_n(1); lit("rev_dead1", 4'b0000);
    cyc_n(1); lit("rev_dead2", 4'b0000);
    cyc_n(1); lit("rev", 4'b0101);
    cyc_n(6);
    // reserved commands, then back to auto
    {s1, s2} = 2'b00;
    cmd = 3'b110; cyc_n(2); lit("cmd110", 4'b0000); cyc_n(8);
    cmd = 3'b111; cyc_n(2); lit("cmd111", 4'b0000); cyc_n(8);
    cmd = 3'b000; cyc_n(2); lit("auto_back", 4'b1010); cyc_n(8);
    // reset inside reversal dead-time
    cmd = 3'b101;
    cyc_n(2); lit("dead_entry", 4'b0000);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 lit("rst_dead", 4'b0000);
    fresh_reset();
    // reset while driving: outputs must drop with no clock edge
    @(posedge clk); #2 lit("drive_pre", 4'b1010);
    rst_n = 1'b0;
    #1 lit("rst_async", 4'b0000);
    fresh_reset();
    // random phase
    for (int i = 0; i < 1500; i++) begin
      cmd = 3'($urandom_range(0, 7));
      {s1, s2} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk); #3 rst_n = 1'b0;
        cyc_n(1);
        rst_n = 1'b1;
      end
      cyc_n($urandom_range(1, 8));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_follower_voice.md
# line_follower_voice

Motor-drive controller for a two-wheel line-following robot with voice-command override. It takes two line sensors and a 3-bit command from the voice-recognition front end, and selects auto (sensor-driven) or manual (command-driven) motion. It drives two H-bridge direction pairs with reversal dead-time protection. It sits between the sensor/voice input logic and the motor driver pins.

## Interface
- DEAD_CYCLES, default 2: number of cycles a motor is held OFF when it reverses direction (FWD↔REV); legal 1..15.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s1  input  1  line sensor 1, asynchronous; 1 = sensor off the line.
- s2  input  1  line sensor 2, asynchronous; 1 = sensor off the line.
- cmd  input  3  voice command, synchronous to clk.
- m1a  output  1  motor 1 forward drive (registered).
- m1b  output  1  motor 1 reverse drive (registered).
- m2a  output  1  motor 2 forward drive (registered).
- m2b  output  1  motor 2 reverse drive (registered).
- Reset is asynchronous, active-low, single clock domain (fixed).

## Operation
- Per-motor drive encoding (a,b): FWD=10, REV=01, OFF=00. 11 is never output.
- Motion targets as (motor1, motor2):
  - FORWARD = (FWD, FWD)
  - RIGHT = (FWD, OFF)
  - LEFT = (OFF, FWD)
  - STOP = (OFF, OFF)
  - REVERSE = (REV, REV)
- cmd decode:
  - 000: AUTO
  - 001: FORWARD
  - 010: RIGHT
  - 011: LEFT
  - 100: STOP
  - 101: REVERSE
  - 110 and 111: STOP (reserved).
- AUTO mode uses synchronized {s1,s2}:
  - 00: FORWARD
  - 10: RIGHT
  - 01: LEFT
  - 11: STOP (line lost)
- In manual mode the sensors are ignored.
- Dead-time, per motor, independently:
  - current FWD with target REV, or REV with target FWD: output OFF for DEAD_CYCLES cycles, then the latest target.
  - Target change during dead-time: the counter keeps running and the latest target is applied at expiry.
  - Target becomes OFF during dead-time: output stays OFF and the counter is cleared.
  - Every other transition (involving OFF, or no change) is applied on the next edge.

## Timing
- Reset values:
  - all motor outputs 0
  - cmd register = 100 (STOP)
  - sensor synchronizer flops = 1 (line lost)
  - dead-time counters = 0
- The robot therefore stays stopped after reset release until real inputs propagate.
- cmd path: 1 register stage plus the output register, so latency is 2 cycles from a cmd change to the outputs.
- Sensor path: 2-flop synchronizer plus the output register, so latency is 3 cycles.
- Direction reversal: latency is the path latency plus DEAD_CYCLES.
- cmd switching between AUTO and manual takes effect with cmd latency; the sensor state used is the already-synchronized value.
- Reset asserted mid-dead-time forces outputs to 0 immediately (asynchronously) and clears the counters.

## Structure
- Shared package lf_pkg holds:
  - cmd encodings (CMD_AUTO … CMD_REVERSE)
  - drive encodings DRV_FWD, DRV_REV, DRV_OFF
  - motion-target constants
- Sub-module motor_deadtime, instantiated twice (one per motor). It takes a target drive and the DEAD_CYCLES parameter and outputs the registered a/b pair.
- Top level contains:
  - sensor synchronizers
  - cmd register
  - mode/target decode (combinational)

## Test plan
- Reset, then cmd=000, s1=0, s2=0 → outputs stay 0000 until 3 cycles after release, then m1a,m1b,m2a,m2b=1010.
- AUTO, sensors 10 / 01 / 11, each held 10 cycles → 1000 / 0010 / 0000, each appearing 3 cycles after the change.
- Manual sequence: cmd 001, 010, 011, 100, each held 10 cycles → 1010, 1000, 0010, 0000, each 2 cycles after the cmd change.
- Reversal: cmd 001 then 101 with DEAD_CYCLES=2 → 1010, then 0000 for exactly 2 cycles, then 0101. a=b=1 never occurs on either motor at any cycle.
- cmd 110 and 111 → 0000. Returning to cmd 000 with sensors 00 → 1010.
- Reset asserted during reversal dead-time → outputs 0000 with no clock edge; after release the behaviour matches the fresh-reset scenario.
